// File: rtl/dma_pkg.sv
// Shared types and constants for the memory-copy DMA engine.
// The MMIO addresses are the targets the engine is commonly pointed at.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    localparam logic [31:0] ADDR_DISPLAY = 32'hC000_0000;
    localparam logic [31:0] ADDR_BUTTON  = 32'hC000_0004;
    localparam logic [31:0] ADDR_SW      = 32'hC000_0008;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_copy_dma_if.sv
// Data-memory port shared between a bus initiator and the RAM + MMIO block.
// The master drives address/data/enable; the slave returns read data and grant.
interface mem_copy_dma_if;
    logic        gnt;
    logic [31:0] bus_rd;
    logic        bus_req;
    logic [31:0] bus_a;
    logic [31:0] bus_wd;
    logic        bus_we;

    modport master (
        input  gnt,
        input  bus_rd,
        output bus_req,
        output bus_a,
        output bus_wd,
        output bus_we
    );

    modport slave (
        output gnt,
        output bus_rd,
        input  bus_req,
        input  bus_a,
        input  bus_wd,
        input  bus_we
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: reads src, writes dst, len times.
// Owns the data-memory port only while gnt is high; gnt low freezes all progress.
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int RD_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    mem_copy_dma_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

    dma_state_t        state, state_next;
    logic [31:0]       src_cur;
    logic [31:0]       dst_cur;
    logic [LEN_W-1:0]  rem;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       data_reg;
    logic              err_q;
    logic              bad_req;
    logic              rd_fire;
    logic              wr_fire;

    assign bad_req = (len == '0) || !is_word_aligned(src) || !is_word_aligned(dst);
    assign rd_fire = (state == RD) && bus.gnt && (wait_cnt == WAIT_LAST);
    assign wr_fire = (state == WR) && bus.gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        bus.bus_req = 1'b0;
        bus.bus_a   = 32'h0;
        bus.bus_wd  = 32'h0;
        bus.bus_we  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = bad_req ? DONE : RD;
                end
            end
            RD: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                bus.bus_a   = src_cur;
                if (rd_fire) begin
                    state_next = WR;
                end
            end
            WR: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                bus.bus_a   = dst_cur;
                bus.bus_wd  = data_reg;
                bus.bus_we  = bus.gnt;
                if (wr_fire) begin
                    state_next = (rem == LEN_W'(1)) ? DONE : RD;
                end
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The wait counter only advances on granted cycles, so a stall never shortens the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cur  <= 32'h0;
            dst_cur  <= 32'h0;
            rem      <= '0;
            wait_cnt <= '0;
            data_reg <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                src_cur  <= src;
                dst_cur  <= dst;
                rem      <= len;
                wait_cnt <= '0;
                err_q    <= bad_req;
            end
            if (state == RD && bus.gnt) begin
                if (wait_cnt == WAIT_LAST) begin
                    data_reg <= bus.bus_rd;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
            if (wr_fire) begin
                src_cur <= src_cur + 32'd4;
                dst_cur <= dst_cur + 32'd4;
                rem     <= rem - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma against a small RAM + MMIO model.
// Table vectors cover plain copies and rejections; hand sequences cover stall, start-ignore and reset.
module tb_mem_copy_dma;
    import dma_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    mem_copy_dma_if bif ();

    mem_copy_dma #(.LEN_W(16), .RD_LAT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .bus   (bif),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] display;
    logic [31:0] sw;
    logic [31:0] logA [$];
    logic [31:0] logD [$];
    int          doneCount;
    int          weViolations;
    logic        busySeen;
    int          checkCount;
    int          passCount;

    always_comb begin
        bif.bus_rd = 32'h0;
        if (bif.bus_a == ADDR_SW) bif.bus_rd = sw;
        else if (bif.bus_a == ADDR_DISPLAY) bif.bus_rd = display;
        else if (bif.bus_a < 32'd1024) bif.bus_rd = mem[bif.bus_a[9:2]];
    end

    // Memory model commits writes on the edge and logs every write the DUT issues.
    always @(posedge clk) begin
        if (bif.bus_we) begin
            logA.push_back(bif.bus_a);
            logD.push_back(bif.bus_wd);
            if (bif.bus_a == ADDR_DISPLAY) display <= bif.bus_wd;
            else if (bif.bus_a < 32'd1024) mem[bif.bus_a[9:2]] <= bif.bus_wd;
        end
        if (done) doneCount++;
    end

    always @(negedge clk) begin
        if (bif.bus_we && !bif.gnt) weViolations++;
        if (busy || bif.bus_req) busySeen = 1'b1;
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        expErr;
        int          expCycle;
        int          nWr;
        logic [31:0] wrA [4];
        logic [31:0] wrD [4];
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        logA.delete();
        logD.delete();
        busySeen = 1'b0;
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound, inout int cyc);
        while (!done && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        checkCount   = 0;
        passCount    = 0;
        doneCount    = 0;
        weViolations = 0;
        busySeen     = 1'b0;
        start   = 1'b0;
        src     = 32'h0;
        dst     = 32'h0;
        len     = 16'd0;
        bif.gnt = 1'b1;
        sw      = 32'h0000_00A5;
        display = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'd1;
        mem[8'h11] = 32'd2;
        mem[8'h12] = 32'd3;
        mem[8'h13] = 32'd4;

        vecs[0] = '{32'h40, 32'h80, 16'd4, 1'b0, 9, 4,
                    '{32'h80, 32'h84, 32'h88, 32'h8C}, '{32'd1, 32'd2, 32'd3, 32'd4}};
        vecs[1] = '{32'h40, 32'h80, 16'd0, 1'b1, 1, 0,
                    '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[2] = '{32'h42, 32'h80, 16'd2, 1'b1, 1, 0,
                    '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[3] = '{32'h40, 32'h81, 16'd1, 1'b1, 1, 0,
                    '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[4] = '{32'hC000_0008, 32'hC000_0000, 16'd1, 1'b0, 3, 1,
                    '{32'hC000_0000, 32'h0, 32'h0, 32'h0}, '{32'h0000_00A5, 32'h0, 32'h0, 32'h0}};
        vecs[5] = '{32'h48, 32'hFFFF_FFFC, 16'd2, 1'b0, 5, 2,
                    '{32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0}, '{32'd3, 32'd4, 32'h0, 32'h0}};

        // Reset values must appear without any clock edge.
        rst_n = 1'b0;
        #1;
        checkOutput("reset busy", {31'h0, busy}, 32'h0);
        checkOutput("reset req/we/done/err", {28'h0, bif.bus_req, bif.bus_we, done, err}, 32'h0);
        checkOutput("reset bus_a", bif.bus_a, 32'h0);
        checkOutput("reset bus_wd", bif.bus_wd, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].len);
            cyc = 1;
            waitDone(100, cyc);
            checkOutput($sformatf("v%0d done", v), {31'h0, done}, 32'h1);
            checkOutput($sformatf("v%0d doneCycle", v), cyc, vecs[v].expCycle);
            checkOutput($sformatf("v%0d err", v), {31'h0, err}, {31'h0, vecs[v].expErr});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d donePulse", v), {31'h0, done}, 32'h0);
            checkOutput($sformatf("v%0d busySeen", v), {31'h0, busySeen}, {31'h0, !vecs[v].expErr});
            checkOutput($sformatf("v%0d nWrites", v), logA.size(), vecs[v].nWr);
            for (int k = 0; k < vecs[v].nWr && k < logA.size(); k++) begin
                checkOutput($sformatf("v%0d wrAddr%0d", v, k), logA[k], vecs[v].wrA[k]);
                checkOutput($sformatf("v%0d wrData%0d", v, k), logD[k], vecs[v].wrD[k]);
            end
        end
        checkOutput("display after mmio copy", display, 32'h0000_00A5);
        checkOutput("wrap landed at 0x0", mem[0], 32'd4);
        checkOutput("ram copy word3", mem[8'h23], 32'd4);

        // Stall in WR of word 2 for three cycles.
        applyStimulus(32'h40, 32'h100, 16'd3);
        cyc = 1;
        while (!done && cyc < 100) begin
            bif.gnt = (cyc >= 4 && cyc <= 6) ? 1'b0 : 1'b1;
            if (cyc == 4) begin
                #1;
                checkOutput("stall bus_we", {31'h0, bif.bus_we}, 32'h0);
                checkOutput("stall bus_a", bif.bus_a, 32'h104);
                checkOutput("stall busy", {31'h0, busy}, 32'h1);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bif.gnt = 1'b1;
        checkOutput("stall doneCycle", cyc, 10);
        checkOutput("stall nWrites", logA.size(), 3);
        @(posedge clk);
        #1;
        checkOutput("stall ram0", mem[8'h40], 32'd1);
        checkOutput("stall ram1", mem[8'h41], 32'd2);
        checkOutput("stall ram2", mem[8'h42], 32'd3);

        // Start pulses while busy and in DONE must be ignored.
        doneCount = 0;
        applyStimulus(32'h40, 32'h200, 16'd8);
        cyc = 1;
        while (!done && cyc < 100) begin
            if (cyc == 3 || cyc == 9) begin
                start = 1'b1;
                src   = 32'h42;
                len   = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ignore doneCycle", cyc, 17);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ignore doneCount", doneCount, 1);
        checkOutput("ignore nWrites", logA.size(), 8);
        checkOutput("ignore lastAddr", (logA.size() == 8) ? logA[7] : 32'hDEAD_BEEF, 32'h21C);
        checkOutput("ignore idle busy", {31'h0, busy}, 32'h0);

        // Async reset mid-copy drops the bus immediately.
        applyStimulus(32'h40, 32'h300, 16'd8);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst busy", {31'h0, busy}, 32'h0);
        checkOutput("rst req/we", {30'h0, bif.bus_req, bif.bus_we}, 32'h0);
        checkOutput("rst bus_a", bif.bus_a, 32'h0);
        checkOutput("rst partial writes", logA.size(), 2);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post-rst idle", {30'h0, busy, done}, 32'h0);
        checkOutput("post-rst doneCount", doneCount, 0);
        checkOutput("we only with gnt", weViolations, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
